lcd1602_screen_ctrl: RTL and testbench

Screen-buffer controller in front of `lcd1602_drive`. Holds a 2×16 character frame buffer written by application logic, tracks which cells changed, and sequences one drive transaction (`user_show_flag` + `{DDRAM address cmd, char}`) per dirty cell, waiting on `show_done` before the next. Application logic writes characters at any rate; the block serialises them onto the single LCD drive.

---
 rtl/lcd1602_screen_ctrl_if.sv | 24 ++
 rtl/lcd1602_screen_ctrl.sv | 93 +++++++++
 tb/tb_lcd1602_screen_ctrl.sv | 333 +++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/lcd1602_screen_ctrl_if.sv
// Application-side and drive-side signal bundle for lcd1602_screen_ctrl.
// The controller uses the slave modport; the application/drive side uses master.
interface lcd1602_screen_ctrl_if;
  logic        wr_en;
  logic [4:0]  wr_addr;
  logic [7:0]  wr_char;
  logic        refresh_all;
  logic        busy;
  logic        timeout_err;
  logic        drv_ready;
  logic        drv_done;
  logic        drv_show_flag;
  logic [15:0] drv_addr_data;

  modport master (
    output wr_en, wr_addr, wr_char, refresh_all, drv_ready, drv_done,
    input  busy, timeout_err, drv_show_flag, drv_addr_data
  );

  modport slave (
    input  wr_en, wr_addr, wr_char, refresh_all, drv_ready, drv_done,
    output busy, timeout_err, drv_show_flag, drv_addr_data
  );
endinterface

// File: rtl/lcd1602_screen_ctrl.sv
// 2x16 frame buffer with per-cell dirty tracking, serialising changed cells onto lcd1602_drive.
// Define LCD_SCREEN_DEDUP_EN to suppress dirty marking for writes that leave a cell unchanged.
module lcd1602_screen_ctrl #(
  parameter logic [7:0]  ROW0_BASE    = 8'h80,
  parameter logic [7:0]  ROW1_BASE    = 8'hC0,
  parameter logic [23:0] DONE_TIMEOUT = 24'd5_000_000
) (
  input logic                 clk,
  input logic                 rst,
  lcd1602_screen_ctrl_if.slave bus
);

  typedef enum logic [1:0] {
    S_WAIT_READY,
    S_SCAN,
    S_ISSUE,
    S_WAIT_DONE
  } state_t;

  state_t      state;
  logic [7:0]  char_buf [32];
  logic [31:0] dirty;
  logic [4:0]  ptr;
  logic [23:0] tmo_cnt;
  logic        show_flag;
  logic [15:0] addr_data;
  logic        tmo_err;
  logic        wr_mark;
  logic [7:0]  row_base;

  always_comb begin
    wr_mark = bus.wr_en;
`ifdef LCD_SCREEN_DEDUP_EN
    wr_mark = bus.wr_en && (char_buf[bus.wr_addr] != bus.wr_char);
`endif
    row_base = ptr[4] ? ROW1_BASE : ROW0_BASE;
  end

  // Dirty updates are ordered so later sets override the issue-time clear.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= S_WAIT_READY;
      ptr       <= '0;
      dirty     <= '1;
      tmo_cnt   <= '0;
      show_flag <= 1'b0;
      addr_data <= '0;
      tmo_err   <= 1'b0;
      for (int unsigned i = 0; i < 32; i++) char_buf[i[4:0]] <= 8'h20;
    end else begin
      show_flag <= 1'b0;
      tmo_err   <= 1'b0;
      case (state)
        S_WAIT_READY: begin
          if (bus.drv_ready) state <= S_SCAN;
        end
        S_SCAN: begin
          if (dirty[ptr]) state <= S_ISSUE;
          else            ptr   <= ptr + 5'd1;
        end
        S_ISSUE: begin
          show_flag  <= 1'b1;
          addr_data  <= {row_base + {4'd0, ptr[3:0]}, char_buf[ptr]};
          dirty[ptr] <= 1'b0;
          tmo_cnt    <= '0;
          state      <= S_WAIT_DONE;
        end
        S_WAIT_DONE: begin
          if (bus.drv_done) begin
            ptr   <= ptr + 5'd1;
            state <= S_WAIT_READY;
          end else if (tmo_cnt == DONE_TIMEOUT - 24'd1) begin
            tmo_err    <= 1'b1;
            dirty[ptr] <= 1'b1;
            state      <= S_WAIT_READY;
          end else begin
            tmo_cnt <= tmo_cnt + 24'd1;
          end
        end
        default: state <= S_WAIT_READY;
      endcase
      if (bus.wr_en)       char_buf[bus.wr_addr] <= bus.wr_char;
      if (wr_mark)         dirty[bus.wr_addr]    <= 1'b1;
      if (bus.refresh_all) dirty                 <= '1;
    end
  end

  assign bus.busy          = (|dirty) | (state != S_SCAN);
  assign bus.timeout_err   = tmo_err;
  assign bus.drv_show_flag = show_flag;
  assign bus.drv_addr_data = addr_data;

endmodule

// File: tb/tb_lcd1602_screen_ctrl.sv
// Scoreboard bench for lcd1602_screen_ctrl: expected transfers are queued by the stimulus,
// popped and compared by an independent monitor; a stub models the LCD drive handshake.
module tb_lcd1602_screen_ctrl;

  logic clk = 1'b0;
  logic rst;
  always #10 clk = ~clk;

  lcd1602_screen_ctrl_if bus ();

  lcd1602_screen_ctrl #(
    .ROW0_BASE(8'h80),
    .ROW1_BASE(8'hC0),
    .DONE_TIMEOUT(24'd16)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  int unsigned vectors = 0;
  int unsigned miscompares = 0;
  int unsigned cyc = 0;
  int unsigned flag_cnt = 0;
  int unsigned tmo_cnt = 0;
  int unsigned last_flag_cyc = 0;
  int unsigned last_tmo_cyc = 0;
  bit          outstanding = 1'b0;
  bit          ready_en = 1'b0;
  bit          hold = 1'b0;
  bit          force_rdy = 1'b0;
  bit          done_en = 1'b1;
  int unsigned done_cd = 0;

  logic [15:0] exp_q [$];
  logic [7:0]  m_buf [32];
  logic [4:0]  b_addr [$];
  logic [7:0]  b_char [$];
  bit          b_ref [$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // Screen position of a cell is row base plus column; payload is the last char written.
  function automatic logic [15:0] expected_word(input int unsigned c);
    logic [7:0] base;
    base = (c >= 16) ? 8'hC0 : 8'h80;
    return {base + 8'(c % 16), m_buf[c]};
  endfunction

  function automatic bit model_write(input logic [4:0] a, input logic [7:0] c);
    bit mark;
    mark = 1'b1;
`ifdef LCD_SCREEN_DEDUP_EN
    mark = (m_buf[a] != c);
`endif
    m_buf[a] = c;
    return mark;
  endfunction

  // Round-robin service order: dirty cells visited cyclically from the start cell.
  function automatic void push_scan(input logic [31:0] dmask, input int unsigned start);
    for (int unsigned i = 0; i < 32; i++) begin
      int unsigned c;
      c = (start + i) % 32;
      if (dmask[c]) exp_q.push_back(expected_word(c));
    end
  endfunction

  // Monitor: samples 1 time unit after each rising edge.
  always @(posedge clk) begin
    logic [15:0] exp;
    cyc++;
    #1;
    if (rst) begin
      outstanding = 1'b0;
    end else begin
      if (bus.drv_show_flag === 1'b1) begin
        flag_cnt++;
        last_flag_cyc = cyc;
        check("single_flag_per_transfer", {31'd0, outstanding}, 32'd0);
        outstanding = 1'b1;
        if (exp_q.size() == 0) begin
          vectors++;
          miscompares++;
          $display("FAIL unexpected_flag: got %h, expected no transfer", bus.drv_addr_data);
        end else begin
          exp = exp_q.pop_front();
          check("flag_addr_data", {16'd0, bus.drv_addr_data}, {16'd0, exp});
        end
      end
      if (bus.drv_done === 1'b1 || bus.timeout_err === 1'b1) outstanding = 1'b0;
      if (bus.timeout_err === 1'b1) begin
        tmo_cnt++;
        last_tmo_cyc = cyc;
      end
    end
  end

  // Drive stub: done three cycles after each flag; ready offered only while work is expected.
  always @(negedge clk) begin
    bus.drv_done = 1'b0;
    if (rst) begin
      done_cd = 0;
    end else begin
      if (done_cd != 0) begin
        done_cd--;
        if (done_cd == 0) bus.drv_done = 1'b1;
      end
      if (bus.drv_show_flag === 1'b1 && done_en) done_cd = 3;
    end
    bus.drv_ready = force_rdy || (ready_en && !hold && exp_q.size() != 0);
  end

  task automatic wr(input logic [4:0] a, input logic [7:0] c, input bit refresh,
                    output int unsigned edge_no);
    @(negedge clk);
    bus.wr_en       = 1'b1;
    bus.wr_addr     = a;
    bus.wr_char     = c;
    bus.refresh_all = refresh;
    edge_no         = cyc + 1;
    @(negedge clk);
    bus.wr_en       = 1'b0;
    bus.refresh_all = 1'b0;
  endtask

  task automatic wait_flag(input string name, input int unsigned old);
    int unsigned n;
    n = 0;
    while (flag_cnt == old && n < 100) begin
      @(negedge clk);
      n++;
    end
    check({name, "_flag_seen"}, {31'd0, flag_cnt != old}, 32'd1);
  endtask

  task automatic wait_drain(input string name);
    int unsigned n;
    n = 0;
    while ((exp_q.size() != 0 || outstanding) && n < 3000) begin
      @(negedge clk);
      n++;
    end
    check({name, "_drained"}, {31'd0, n < 3000}, 32'd1);
  endtask

  // Let the DUT run freely so any unexpected dirty cell shows up as an unexpected flag.
  task automatic quiesce(input string name);
    int unsigned n;
    n = 0;
    force_rdy = 1'b1;
    @(negedge clk);
    while (bus.busy !== 1'b0 && n < 400) begin
      @(negedge clk);
      n++;
    end
    check({name, "_busy_low"}, {31'd0, bus.busy}, 32'd0);
    repeat (40) @(negedge clk);
    check({name, "_queue_empty"}, exp_q.size(), 32'd0);
    force_rdy = 1'b0;
  endtask

  task automatic run_batch(input string name);
    logic [4:0]  a;
    logic [7:0]  ch;
    logic [31:0] mask;
    int unsigned f0, n_exp, e, old;
    a   = 5'($urandom_range(0, 31));
    ch  = m_buf[a] ^ 8'h01;
    old = flag_cnt;
    void'(model_write(a, ch));
    exp_q.push_back(expected_word(a));
    wr(a, ch, 1'b0, e);
    wait_flag({name, "_anchor"}, old);
    hold = 1'b1;
    mask = '0;
    foreach (b_addr[i]) begin
      if (model_write(b_addr[i], b_char[i])) mask[b_addr[i]] = 1'b1;
      if (b_ref[i]) mask = '1;
      wr(b_addr[i], b_char[i], b_ref[i], e);
    end
    f0    = flag_cnt;
    n_exp = $countones(mask);
    push_scan(mask, (32'(a) + 1) % 32);
    hold = 1'b0;
    wait_drain(name);
    quiesce(name);
    check({name, "_transfers"}, flag_cnt - f0, n_exp);
    b_addr.delete();
    b_char.delete();
    b_ref.delete();
  endtask

  initial begin
    int unsigned e, f0, t0, fcyc;
    bit mark;
    rst             = 1'b1;
    bus.wr_en       = 1'b0;
    bus.wr_addr     = '0;
    bus.wr_char     = '0;
    bus.refresh_all = 1'b0;
    for (int i = 0; i < 32; i++) m_buf[i] = 8'h20;
    push_scan('1, 0);
    repeat (3) @(negedge clk);
    check("reset_show_flag", {31'd0, bus.drv_show_flag}, 32'd0);
    check("reset_addr_data", {16'd0, bus.drv_addr_data}, 32'd0);
    check("reset_busy", {31'd0, bus.busy}, 32'd1);
    check("reset_timeout_err", {31'd0, bus.timeout_err}, 32'd0);
    rst = 1'b0;
    flag_cnt = 0;

    // Drive not ready for 100 cycles: nothing may be issued.
    repeat (100) @(negedge clk);
    check("no_flag_without_ready", flag_cnt, 32'd0);
    ready_en = 1'b1;
    wait_drain("blank");
    check("blank_transfers", flag_cnt, 32'd32);
    quiesce("blank");

    // Single write from idle: one transfer within 33 cycles.
    f0 = flag_cnt;
    mark = model_write(5'h13, 8'h41);
    if (mark) exp_q.push_back(expected_word(32'h13));
    wr(5'h13, 8'h41, 1'b0, e);
    wait_flag("single", f0);
    check("single_latency_ok", {31'd0, (last_flag_cyc - e) <= 33}, 32'd1);
    wait_drain("single");
    quiesce("single");
    check("single_transfers", flag_cnt - f0, 32'd1);

    // Rewrite of cell 0 while its transfer is awaiting done.
    f0 = flag_cnt;
    void'(model_write(5'h00, 8'h41));
    exp_q.push_back(expected_word(0));
    wr(5'h00, 8'h41, 1'b0, e);
    wait_flag("collide", f0);
    void'(model_write(5'h00, 8'h42));
    exp_q.push_back(expected_word(0));
    wr(5'h00, 8'h42, 1'b0, e);
    wait_drain("collide");
    quiesce("collide");
    check("collide_transfers", flag_cnt - f0, 32'd2);

    // No done from the drive: timeout 16 cycles after the flag, then the same cell again.
    done_en = 1'b0;
    f0 = flag_cnt;
    t0 = tmo_cnt;
    void'(model_write(5'h07, 8'h55));
    exp_q.push_back(expected_word(7));
    wr(5'h07, 8'h55, 1'b0, e);
    wait_flag("timeout", f0);
    fcyc = last_flag_cyc;
    exp_q.push_back(expected_word(7));
    e = 0;
    while (tmo_cnt == t0 && e < 40) begin
      @(negedge clk);
      e++;
    end
    check("timeout_seen", {31'd0, tmo_cnt != t0}, 32'd1);
    check("timeout_delay", last_tmo_cyc - fcyc, 32'd16);
    done_en = 1'b1;
    wait_drain("timeout");
    quiesce("timeout");
    check("timeout_pulse_count", tmo_cnt - t0, 32'd1);
    check("timeout_transfers", flag_cnt - f0, 32'd2);

    // Same char rewritten to a clean cell.
    f0 = flag_cnt;
    mark = model_write(5'h07, 8'h55);
    if (mark) exp_q.push_back(expected_word(7));
    wr(5'h07, 8'h55, 1'b0, e);
    wait_drain("rewrite");
    quiesce("rewrite");
`ifdef LCD_SCREEN_DEDUP_EN
    check("rewrite_transfers", flag_cnt - f0, 32'd0);
`else
    check("rewrite_transfers", flag_cnt - f0, 32'd1);
`endif

    // refresh_all together with a write: full screen with the new char.
    b_addr.push_back(5'h1A);
    b_char.push_back(8'h7E);
    b_ref.push_back(1'b1);
    run_batch("refresh_write");

    for (int b = 0; b < 6; b++) begin
      int unsigned n;
      n = $urandom_range(1, 10);
      for (int unsigned k = 0; k < n; k++) begin
        b_addr.push_back(5'($urandom_range(0, 31)));
        b_char.push_back(8'(8'h41 + $urandom_range(0, 2)));
        b_ref.push_back($urandom_range(0, 7) == 0);
      end
      run_batch("rand_batch");
    end

    // Reset in the middle of a transfer re-blanks the whole screen.
    f0 = flag_cnt;
    void'(model_write(5'h03, 8'h61));
    exp_q.push_back(expected_word(3));
    wr(5'h03, 8'h61, 1'b0, e);
    wait_flag("midreset", f0);
    @(negedge clk);
    rst = 1'b1;
    exp_q.delete();
    for (int i = 0; i < 32; i++) m_buf[i] = 8'h20;
    push_scan('1, 0);
    repeat (2) @(negedge clk);
    check("midreset_busy", {31'd0, bus.busy}, 32'd1);
    check("midreset_show_flag", {31'd0, bus.drv_show_flag}, 32'd0);
    f0 = flag_cnt;
    rst = 1'b0;
    wait_drain("midreset");
    quiesce("midreset");
    check("midreset_transfers", flag_cnt - f0, 32'd32);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #1_500_000;
    $display("FAIL watchdog: got no completion, expected run to finish");
    $fatal(1, "watchdog expired");
  end

endmodule
